// File: rtl/table_mac_sched.sv
// Round-robin scheduler that shares one coefficient table and one MAC datapath
// between an accumulate-up channel (0) and an accumulate-down channel (1).
//
// state | meaning
// INIT  | table load sequencer writes T[i] = i, one entry per edge
// IDLE  | waiting for a request; grants one channel and latches its operands
// ACC   | updates the granted channel's accumulator
// OUT   | computes and registers the result, pulses xvalid
module table_mac_sched #(
    parameter int NBITS    = 8,
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int ACC_INIT = 21
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0,
    input  logic                     req1,
    input  logic [NBITS-1:0]         a0,
    input  logic [NBITS-1:0]         b0,
    input  logic [NBITS-1:0]         a1,
    input  logic [NBITS-1:0]         b1,
    input  logic                     cfg_we,
    input  logic [$clog2(ROWS)-1:0]  cfg_row,
    input  logic [$clog2(COLS)-1:0]  cfg_col,
    input  logic [NBITS-1:0]         cfg_data,
    output logic [1:0]               gnt,
    output logic [NBITS-1:0]         xout,
    output logic                     xvalid,
    output logic                     xsrc,
    output logic                     busy,
    output logic                     init_done
);
    localparam int DEPTH  = ROWS * COLS;
    localparam int AW     = $clog2(DEPTH);
    localparam int T0_IDX = 1 * COLS + 2;
    localparam int T1_IDX = 2 * COLS + 1;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACC, S_OUT} state_t;

    state_t           state, state_nx;
    logic [AW-1:0]    init_left, init_left_nx;
    logic             init_done_nx;
    logic             rr_last, rr_nx;
    logic             ch, ch_nx;
    logic [NBITS-1:0] a_q, a_nx, b_q, b_nx;
    logic [NBITS-1:0] acc0, acc0_nx, acc1, acc1_nx;
    logic [1:0]       gnt_nx;
    logic [NBITS-1:0] xout_nx;
    logic             xvalid_nx, xsrc_nx;
    logic             pick;
    logic [NBITS-1:0] res0, res1;

    logic             tbl_we;
    logic [AW-1:0]    tbl_addr;
    logic [NBITS-1:0] tbl_din;
    logic [NBITS-1:0] tbl [DEPTH];

    // Table has no reset; INIT rewrites every entry after each reset.
    always_ff @(posedge clk) begin
        if (tbl_we) tbl[tbl_addr] <= tbl_din;
    end

    always_comb begin
        tbl_we   = 1'b0;
        tbl_addr = AW'(cfg_row) * AW'(COLS) + AW'(cfg_col);
        tbl_din  = cfg_data;
        if (state == S_INIT) begin
            tbl_we   = 1'b1;
            tbl_addr = AW'(DEPTH - 1) - init_left;
            tbl_din  = NBITS'(tbl_addr);
        end else if (cfg_we) begin
            tbl_we = 1'b1;
        end
    end

    // Both results read the table before any same-edge config write lands.
    always_comb begin
        res0 = a_q - b_q * NBITS'(3) - acc0 * tbl[T0_IDX] + NBITS'(11);
        res1 = a_q - b_q * NBITS'(7) - acc1 * tbl[T1_IDX] + NBITS'(17);
    end

    // On a tie the channel not granted last wins; otherwise the lone requester.
    assign pick = (req0 & req1) ? ~rr_last : ~req0;
    assign busy = (state != S_IDLE);

    always_comb begin
        state_nx     = state;
        init_left_nx = init_left;
        init_done_nx = init_done;
        rr_nx        = rr_last;
        ch_nx        = ch;
        a_nx         = a_q;
        b_nx         = b_q;
        acc0_nx      = acc0;
        acc1_nx      = acc1;
        gnt_nx       = 2'b00;
        xout_nx      = xout;
        xvalid_nx    = 1'b0;
        xsrc_nx      = xsrc;
        case (state)
            S_INIT: begin
                if (init_left == '0) begin
                    init_done_nx = 1'b1;
                    state_nx     = S_IDLE;
                end else begin
                    init_left_nx = init_left - 1'b1;
                end
            end
            S_IDLE: begin
                if (req0 | req1) begin
                    gnt_nx   = pick ? 2'b10 : 2'b01;
                    ch_nx    = pick;
                    rr_nx    = pick;
                    a_nx     = pick ? a1 : a0;
                    b_nx     = pick ? b1 : b0;
                    state_nx = S_ACC;
                end
            end
            S_ACC: begin
                if (ch) acc1_nx = acc1 - (a_q - b_q);
                else    acc0_nx = acc0 + (a_q + b_q);
                state_nx = S_OUT;
            end
            S_OUT: begin
                xout_nx   = ch ? res1 : res0;
                xvalid_nx = 1'b1;
                xsrc_nx   = ch;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INIT;
            init_left <= AW'(DEPTH - 1);
            init_done <= 1'b0;
            rr_last   <= 1'b1;
            ch        <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc0      <= NBITS'(ACC_INIT);
            acc1      <= NBITS'(ACC_INIT);
            gnt       <= 2'b00;
            xout      <= '0;
            xvalid    <= 1'b0;
            xsrc      <= 1'b0;
        end else begin
            state     <= state_nx;
            init_left <= init_left_nx;
            init_done <= init_done_nx;
            rr_last   <= rr_nx;
            ch        <= ch_nx;
            a_q       <= a_nx;
            b_q       <= b_nx;
            acc0      <= acc0_nx;
            acc1      <= acc1_nx;
            gnt       <= gnt_nx;
            xout      <= xout_nx;
            xvalid    <= xvalid_nx;
            xsrc      <= xsrc_nx;
        end
    end
endmodule

// File: tb/tb_table_mac_sched.sv
// Self-checking bench for table_mac_sched: directed scenarios plus randomized
// transactions checked against an arithmetic model of table, accumulators and arbiter.
module tb_table_mac_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, cfg_we = 1'b0;
    logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0, cfg_data = '0;
    logic [1:0] cfg_row = '0, cfg_col = '0;
    logic [1:0] gnt;
    logic [7:0] xout;
    logic       xvalid, xsrc, busy, init_done;

    int vectors = 0;
    int miscompares = 0;

    int m_tbl[16];
    int m_acc0, m_acc1, m_rr;

    table_mac_sched #(.NBITS(8), .ROWS(4), .COLS(4), .ACC_INIT(21)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_col(cfg_col), .cfg_data(cfg_data),
        .gnt(gnt), .xout(xout), .xvalid(xvalid), .xsrc(xsrc),
        .busy(busy), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) m_tbl[i] = i;
        m_acc0 = 21;
        m_acc1 = 21;
        m_rr   = 1;
    endfunction

    function automatic int m_pick(bit r0, bit r1);
        if (r0 && r1) return (m_rr == 1) ? 0 : 1;
        return r1 ? 1 : 0;
    endfunction

    function automatic int m_exec(int chn, int a, int b);
        int x;
        if (chn == 0) begin
            m_acc0 = (m_acc0 + a + b) & 255;
            x = a - 3 * b - m_acc0 * m_tbl[1*4+2] + 11;
        end else begin
            m_acc1 = (m_acc1 - (a - b)) & 255;
            x = a - 7 * b - m_acc1 * m_tbl[2*4+1] + 17;
        end
        m_rr = chn;
        return x & 255;
    endfunction

    task automatic reset_init();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (16) tick();
        m_reset();
    endtask

    // Drives one transaction and reports what the DUT did; comparisons stay in the callers.
    task automatic do_txn(input logic r0, input logic r1,
                          input logic [7:0] x0, input logic [7:0] y0,
                          input logic [7:0] x1, input logic [7:0] y1,
                          input bit drop, input bit rel, input bit cfg_out,
                          input logic [1:0] cr, input logic [1:0] cc, input logic [7:0] cd,
                          output logic [1:0] g, output int waited,
                          output logic v1, output logic v2,
                          output logic [7:0] xo, output logic so);
        req0 = r0; req1 = r1;
        a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        waited = 0;
        g = 2'b00;
        while (waited < 12) begin
            tick();
            waited++;
            if (gnt !== 2'b00) break;
        end
        g = gnt;
        if (drop) begin
            if (g == 2'b01) req0 = 1'b0;
            if (g == 2'b10) req1 = 1'b0;
        end
        tick();
        v1 = xvalid;
        if (cfg_out) begin
            cfg_we = 1'b1; cfg_row = cr; cfg_col = cc; cfg_data = cd;
        end
        tick();
        cfg_we = 1'b0;
        v2 = xvalid;
        xo = xout;
        so = xsrc;
        if (rel) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL rst_gnt: got %b expected 00", gnt); end
        vectors++; if (xout !== 8'd0) begin miscompares++; $display("FAIL rst_xout: got %0d expected 0", xout); end
        vectors++; if (xvalid !== 1'b0) begin miscompares++; $display("FAIL rst_xvalid: got %b expected 0", xvalid); end
        vectors++; if (xsrc !== 1'b0) begin miscompares++; $display("FAIL rst_xsrc: got %b expected 0", xsrc); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_busy: got %b expected 1", busy); end
        vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL rst_init_done: got %b expected 0", init_done); end
        tick();
        // requests and config writes during INIT must have no effect
        req0 = 1'b1; a0 = 8'd1; b0 = 8'd1;
        cfg_we = 1'b1; cfg_row = 2'd1; cfg_col = 2'd2; cfg_data = 8'd99;
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL init_gnt edge %0d: got %b expected 00", k, gnt); end
            vectors++; if (init_done !== (k == 16)) begin miscompares++; $display("FAIL init_done edge %0d: got %b expected %b", k, init_done, (k == 16)); end
            vectors++; if (busy !== (k < 16)) begin miscompares++; $display("FAIL init_busy edge %0d: got %b expected %b", k, busy, (k < 16)); end
        end
        req0 = 1'b0;
        cfg_we = 1'b0;
        m_reset();
    endtask

    task automatic test_ch0();
        logic [1:0] g; int w; logic v1, v2, so; logic [7:0] xo; int exp_x;
        void'(m_pick(1'b1, 1'b0));
        exp_x = m_exec(0, 5, 2);
        do_txn(1'b1, 1'b0, 8'd5, 8'd2, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0, g, w, v1, v2, xo, so);
        vectors++; if (g !== 2'b01) begin miscompares++; $display("FAIL ch0_gnt: got %b expected 01", g); end
        vectors++; if (w != 1) begin miscompares++; $display("FAIL ch0_grant_edge: got %0d expected 1", w); end
        vectors++; if (v1 !== 1'b0) begin miscompares++; $display("FAIL ch0_xvalid_e1: got %b expected 0", v1); end
        vectors++; if (v2 !== 1'b1) begin miscompares++; $display("FAIL ch0_xvalid_e2: got %b expected 1", v2); end
        vectors++; if (xo !== 8'(exp_x)) begin miscompares++; $display("FAIL ch0_xout_model: got %0d expected %0d", xo, exp_x); end
        vectors++; if (xo !== 8'd98) begin miscompares++; $display("FAIL ch0_xout: got %0d expected 98", xo); end
        vectors++; if (so !== 1'b0) begin miscompares++; $display("FAIL ch0_xsrc: got %b expected 0", so); end
        tick();
        vectors++; if (xvalid !== 1'b0 || xout !== 8'd98) begin miscompares++; $display("FAIL ch0_hold: got xvalid=%b xout=%0d expected 0/98", xvalid, xout); end
    endtask

    task automatic test_ch1();
        logic [1:0] g; int w; logic v1, v2, so; logic [7:0] xo; int exp_x;
        reset_init();
        exp_x = m_exec(1, 10, 3);
        do_txn(1'b0, 1'b1, 8'd0, 8'd0, 8'd10, 8'd3, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0, g, w, v1, v2, xo, so);
        vectors++; if (g !== 2'b10) begin miscompares++; $display("FAIL ch1_gnt: got %b expected 10", g); end
        vectors++; if (v2 !== 1'b1) begin miscompares++; $display("FAIL ch1_xvalid: got %b expected 1", v2); end
        vectors++; if (xo !== 8'(exp_x) || xo !== 8'd136) begin miscompares++; $display("FAIL ch1_xout: got %0d expected %0d", xo, exp_x); end
        vectors++; if (so !== 1'b1) begin miscompares++; $display("FAIL ch1_xsrc: got %b expected 1", so); end
    endtask

    task automatic test_tie();
        logic [1:0] g; int w; logic v1, v2, so; logic [7:0] xo; int exp_x, chn;
        logic [7:0] x0, y0, x1, y1;
        reset_init();
        x0 = 8'($urandom_range(0, 255)); y0 = 8'($urandom_range(0, 255));
        x1 = 8'($urandom_range(0, 255)); y1 = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) begin
            chn = m_pick(1'b1, 1'b1);
            exp_x = m_exec(chn, int'(chn ? x1 : x0), int'(chn ? y1 : y0));
            do_txn(1'b1, 1'b1, x0, y0, x1, y1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, g, w, v1, v2, xo, so);
            vectors++; if (g !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin miscompares++; $display("FAIL tie_gnt %0d: got %b expected ch%0d", i, g, i % 2); end
            vectors++; if (w != 1) begin miscompares++; $display("FAIL tie_spacing %0d: got %0d expected 1", i, w); end
            vectors++; if (xo !== 8'(exp_x) || v2 !== 1'b1) begin miscompares++; $display("FAIL tie_xout %0d: got %0d/%b expected %0d/1", i, xo, v2, exp_x); end
            vectors++; if (so !== 1'(i % 2)) begin miscompares++; $display("FAIL tie_xsrc %0d: got %b expected %0d", i, so, i % 2); end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL tie_release: got %b expected 00", gnt); end
    endtask

    task automatic test_config_wrap();
        logic [1:0] g; int w; logic v1, v2, so; logic [7:0] xo; int exp_x;
        reset_init();
        cfg_we = 1'b1; cfg_row = 2'd1; cfg_col = 2'd2; cfg_data = 8'd0;
        tick();
        cfg_we = 1'b0;
        m_tbl[1*4+2] = 0;
        exp_x = m_exec(0, 5, 2);
        do_txn(1'b1, 1'b0, 8'd5, 8'd2, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0, g, w, v1, v2, xo, so);
        vectors++; if (xo !== 8'(exp_x) || xo !== 8'd10) begin miscompares++; $display("FAIL cfg_xout: got %0d expected %0d", xo, exp_x); end
        // same-edge write of T[1][2] must not affect this result
        exp_x = m_exec(0, 200, 100);
        do_txn(1'b1, 1'b0, 8'd200, 8'd100, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1, 2'd1, 2'd2, 8'd5, g, w, v1, v2, xo, so);
        m_tbl[1*4+2] = 5;
        vectors++; if (xo !== 8'(exp_x) || xo !== 8'd167) begin miscompares++; $display("FAIL wrap_xout: got %0d expected %0d", xo, exp_x); end
        exp_x = m_exec(0, 3, 4);
        do_txn(1'b1, 1'b0, 8'd3, 8'd4, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0, g, w, v1, v2, xo, so);
        vectors++; if (xo !== 8'(exp_x)) begin miscompares++; $display("FAIL cfg_late_xout: got %0d expected %0d", xo, exp_x); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] g; int w; logic v1, v2, so; logic [7:0] xo; int exp_x;
        reset_init();
        exp_x = m_exec(1, 10, 3);
        do_txn(1'b0, 1'b1, 8'd0, 8'd0, 8'd10, 8'd3, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0, g, w, v1, v2, xo, so);
        vectors++; if (xo !== 8'(exp_x)) begin miscompares++; $display("FAIL mid_pre_xout: got %0d expected %0d", xo, exp_x); end
        req0 = 1'b1; a0 = 8'd5; b0 = 8'd2;
        tick();
        vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL mid_gnt: got %b expected 01", gnt); end
        req0 = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        vectors++; if (xout !== 8'd0 || xsrc !== 1'b0 || xvalid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_out: got xout=%0d xsrc=%b xvalid=%b expected 0/0/0", xout, xsrc, xvalid); end
        vectors++; if (busy !== 1'b1 || init_done !== 1'b0 || gnt !== 2'b00) begin miscompares++; $display("FAIL mid_rst_status: got busy=%b init_done=%b gnt=%b expected 1/0/00", busy, init_done, gnt); end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++; if (xvalid !== 1'b0) begin miscompares++; $display("FAIL mid_no_xvalid %0d: got %b expected 0", k, xvalid); end
        end
        rst_n = 1'b1;
        repeat (16) tick();
        m_reset();
        vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL mid_reinit: got %b expected 1", init_done); end
        exp_x = m_exec(0, 5, 2);
        do_txn(1'b1, 1'b0, 8'd5, 8'd2, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0, g, w, v1, v2, xo, so);
        vectors++; if (xo !== 8'(exp_x) || xo !== 8'd98) begin miscompares++; $display("FAIL mid_post_xout: got %0d expected %0d", xo, exp_x); end
    endtask

    task automatic test_random();
        logic [1:0] g; int w; logic v1, v2, so; logic [7:0] xo; int exp_x, chn;
        logic r0, r1, co;
        logic [7:0] x0, y0, x1, y1, d;
        logic [1:0] cr, cc;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cr = 2'($urandom_range(0, 3)); cc = 2'($urandom_range(0, 3)); d = 8'($urandom_range(0, 255));
                cfg_we = 1'b1; cfg_row = cr; cfg_col = cc; cfg_data = d;
                tick();
                cfg_we = 1'b0;
                m_tbl[int'(cr) * 4 + int'(cc)] = int'(d);
            end
            r0 = 1'($urandom_range(0, 1));
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            x0 = 8'($urandom_range(0, 255)); y0 = 8'($urandom_range(0, 255));
            x1 = 8'($urandom_range(0, 255)); y1 = 8'($urandom_range(0, 255));
            co = ($urandom_range(0, 3) == 0);
            cr = 2'($urandom_range(1, 2)); cc = (cr == 2'd1) ? 2'd2 : 2'd1;
            d = 8'($urandom_range(0, 255));
            chn = m_pick(r0, r1);
            exp_x = m_exec(chn, int'(chn ? x1 : x0), int'(chn ? y1 : y0));
            do_txn(r0, r1, x0, y0, x1, y1, 1'b1, 1'b1, co, cr, cc, d, g, w, v1, v2, xo, so);
            if (co) m_tbl[int'(cr) * 4 + int'(cc)] = int'(d);
            vectors++; if (g !== (chn ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL rand_gnt %0d: got %b expected ch%0d", i, g, chn); end
            vectors++; if (v1 !== 1'b0 || v2 !== 1'b1) begin miscompares++; $display("FAIL rand_latency %0d: got e1=%b e2=%b expected 0/1", i, v1, v2); end
            vectors++; if (xo !== 8'(exp_x)) begin miscompares++; $display("FAIL rand_xout %0d: got %0d expected %0d", i, xo, exp_x); end
            vectors++; if (so !== 1'(chn)) begin miscompares++; $display("FAIL rand_xsrc %0d: got %b expected %0d", i, so, chn); end
        end
    endtask

    initial begin
        test_reset();
        test_ch0();
        test_ch1();
        test_tie();
        test_config_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
